// File: rtl/lsu_access_unit_pkg.sv
// Shared types and small decode helpers for the data-memory access stage.
// Imported by the access unit and by the reusable load extractor.
package lsu_access_unit_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Size code 2'b11 decodes as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            LSU_B:   is_misaligned = 1'b0;
            LSU_H:   is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            LSU_B:   byte_enable = 4'b0001 << offset;
            LSU_H:   byte_enable = 4'b0011 << offset;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Extracts a byte/half/word from a full bus word and sign- or zero-extends it.
// Purely combinational so it can be shared with a cache refill path.
module lsu_load_ext
    import lsu_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = rdata;
        case (size)
            LSU_B:   result = {{(XLEN-8){sign_ext & shifted[7]}}, shifted[7:0]};
            LSU_H:   result = {{(XLEN-16){sign_ext & shifted[15]}}, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_access_unit.sv
// Load/store stage after the ALU: one dmem access per instruction over a
// req/gnt/rvalid bus, with local misalignment detection and load extension.
module lsu_access_unit
    import lsu_access_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              ld_misalign_o,
    output logic              st_misalign_o,
    output logic              fault_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    input  logic              dmem_err_i
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              misaligned;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   load_result;

    assign misaligned = is_misaligned(size_i, addr_i[1:0]);

    always_comb begin
        lane_wdata = wdata_i;
        case (size_i)
            LSU_B:   lane_wdata = {4{wdata_i[7:0]}};
            LSU_H:   lane_wdata = {2{wdata_i[15:0]}};
            default: lane_wdata = wdata_i;
        endcase
    end

    lsu_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rdata   (dmem_rdata_i),
        .offset  (off_q),
        .size    (size_q),
        .sign_ext(sign_q),
        .result  (load_result)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        sign_d        = sign_q;
        off_d         = off_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        stall_o       = 1'b0;
        done_o        = 1'b0;
        ld_misalign_o = 1'b0;
        st_misalign_o = 1'b0;
        dmem_req_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (misaligned) begin
                        ld_misalign_o = ~we_i;
                        st_misalign_o = we_i;
                    end else begin
                        stall_o = 1'b1;
                        we_d    = we_i;
                        size_d  = size_i;
                        sign_d  = sign_ext_i;
                        off_d   = addr_i[1:0];
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        be_d    = byte_enable(size_i, addr_i[1:0]);
                        wdata_d = lane_wdata;
                        fault_d = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o    = 1'b1;
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        fault_d = dmem_err_i;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    fault_d = dmem_err_i;
                    rdata_d = dmem_err_i ? '0 : load_result;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // IDLE outputs follow inputs combinationally; keep them quiet in reset.
        if (!rst_ni) begin
            stall_o       = 1'b0;
            ld_misalign_o = 1'b0;
            st_misalign_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Bus fields are driven only while a request is outstanding.
    assign dmem_we_o    = (state_q == REQ) & we_q;
    assign dmem_addr_o  = (state_q == REQ) ? addr_q : '0;
    assign dmem_be_o    = (state_q == REQ) ? be_q : 4'b0000;
    assign dmem_wdata_o = (state_q == REQ) ? wdata_q : '0;
    assign fault_o      = (state_q == DONE) & fault_q;
    assign rdata_o      = rdata_q;

endmodule
